// File: rtl/irq_mux.sv
// irq_mux: shares one PIC irq input among eight peripheral interrupt sources.
// Source events latch into STATUS (edge or level per source). ENABLE gates
// which pending sources may win arbitration. A winner gets a one-cycle irq
// pulse, and the block then holds until software writes End-Of-Interrupt.
//
// Register map (relative to IRQ_MUX_ADDRESS):
//   +0 ENABLE (R/W)   +1 STATUS (R, W1C)   +2 EDGE (R/W, 1 = rising edge)
//   +3 ACTIVE (R: {busy, 4'b0, active_id}; any write = EOI)
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   din, address      - I/O write data and address
//   w_en, r_en        - write / read strobes
//   dout              - registered read data
//   src               - peripheral interrupt sources
//   irq               - single-cycle request pulse to the PIC
//   active_id         - index of the source fired / in service
//   busy              - high while firing or in service
//
// Build option: define IRQ_MUX_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins) and no pointer register exists.

module irq_mux #(
  parameter logic [7:0] IRQ_MUX_ADDRESS = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic [7:0] src,
  output logic       irq,
  output logic [2:0] active_id,
  output logic       busy
);

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned ID_W    = 3;

  localparam logic [7:0] ADDR_ENABLE = IRQ_MUX_ADDRESS;
  localparam logic [7:0] ADDR_STATUS = 8'(IRQ_MUX_ADDRESS + 8'd1);
  localparam logic [7:0] ADDR_EDGE   = 8'(IRQ_MUX_ADDRESS + 8'd2);
  localparam logic [7:0] ADDR_ACTIVE = 8'(IRQ_MUX_ADDRESS + 8'd3);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FIRE    = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t               state;
  logic [NUM_SRC-1:0]   enable;
  logic [NUM_SRC-1:0]   status;
  logic [NUM_SRC-1:0]   edge_sel;
  logic [NUM_SRC-1:0]   src_prev;

  logic [NUM_SRC-1:0]   pending;
  logic                 has_pending;
  logic [ID_W-1:0]      winner;
  logic                 eoi;
  logic [NUM_SRC-1:0]   set_mask;
  logic [NUM_SRC-1:0]   clr_mask;
  logic [NUM_SRC-1:0]   status_next;
  logic [7:0]           rd_data;

  assign pending     = status & enable;
  assign has_pending = |pending;
  assign eoi         = w_en && (address == ADDR_ACTIVE);

  // Edge sources set on a rising transition, level sources every high cycle
  assign set_mask = (edge_sel & src & ~src_prev) | (~edge_sel & src);

  // W1C write plus EOI clear of the serviced source; EOI only counts in SERVICE
  always_comb begin
    clr_mask = '0;
    if (w_en && (address == ADDR_STATUS)) begin
      clr_mask = din;
    end
    if (eoi && (state == S_SERVICE)) begin
      clr_mask = clr_mask | (NUM_SRC'(1) << active_id);
    end
  end

  // Set has priority over any clear in the same cycle
  assign status_next = (status & ~clr_mask) | set_mask;

`ifdef IRQ_MUX_RR_EN
  logic [ID_W-1:0] rr_ptr;

  // Round-robin: search from the slot after the last grant, wrapping 7 -> 0
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = ID_W'(rr_ptr + ID_W'(i));
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Pointer follows the winner on each grant
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= ID_W'(NUM_SRC - 1);
    end else if ((state == S_IDLE) && has_pending) begin
      rr_ptr <= winner;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest pending index
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winner = ID_W'(i);
      end
    end
  end
`endif

  // Read data mux; unmapped addresses return zero
  always_comb begin
    rd_data = 8'h00;
    if (address == ADDR_ENABLE) begin
      rd_data = enable;
    end else if (address == ADDR_STATUS) begin
      rd_data = status;
    end else if (address == ADDR_EDGE) begin
      rd_data = edge_sel;
    end else if (address == ADDR_ACTIVE) begin
      rd_data = {busy, 4'b0000, active_id};
    end
  end

  // Registers, read port and arbitration FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      enable    <= '0;
      status    <= '0;
      edge_sel  <= '0;
      src_prev  <= '1;
      dout      <= 8'h00;
      irq       <= 1'b0;
      active_id <= '0;
      busy      <= 1'b0;
    end else begin
      src_prev <= src;
      status   <= status_next;

      if (w_en && (address == ADDR_ENABLE)) begin
        enable <= din;
      end
      if (w_en && (address == ADDR_EDGE)) begin
        edge_sel <= din;
      end
      if (r_en) begin
        dout <= rd_data;
      end

      case (state)
        S_IDLE: begin
          if (has_pending) begin
            active_id <= winner;
            irq       <= 1'b1;
            busy      <= 1'b1;
            state     <= S_FIRE;
          end
        end
        S_FIRE: begin
          irq   <= 1'b0;
          state <= S_SERVICE;
        end
        S_SERVICE: begin
          if (eoi) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          irq   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_mux.sv
// tb_irq_mux: directed bench for irq_mux with a scoreboard of expected values.
// Expectations are queued when stimulus is applied and popped when the DUT
// output is sampled, #1 after the rising edge.

module tb_irq_mux;

  localparam logic [7:0] BASE = 8'h40;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic [7:0] src;
  logic       irq;
  logic [2:0] active_id;
  logic       busy;

  int vectors;
  int miscompares;

  string      tag_q[$];
  logic [7:0] exp_q[$];

  irq_mux #(.IRQ_MUX_ADDRESS(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .address   (address),
    .w_en      (w_en),
    .r_en      (r_en),
    .dout      (dout),
    .src       (src),
    .irq       (irq),
    .active_id (active_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [7:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic check_out(input logic [7:0] obs);
    string      t;
    logic [7:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %02h expected <none>", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", t, obs, e);
    end
  endtask

  task automatic expect_now(input string tag, input logic [7:0] exp, input logic [7:0] obs);
    push_exp(tag, exp);
    check_out(obs);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a;
    din     = d;
    w_en    = 1'b1;
    tick();
    w_en    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    address = a;
    r_en    = 1'b1;
    push_exp(tag, exp);
    tick();
    r_en    = 1'b0;
    check_out(dout);
  endtask

  task automatic wait_irq(input int max_cycles, output logic got);
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      tick();
      if (irq) got = 1'b1;
    end
  endtask

  initial begin
    logic got;
    int   hits;
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b1;
    din     = 8'h00;
    address = 8'h00;
    w_en    = 1'b0;
    r_en    = 1'b0;
    src     = 8'h00;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    expect_now("rst_dout", 8'h00, dout);
    expect_now("rst_irq", 8'h00, {7'b0, irq});
    expect_now("rst_busy", 8'h00, {7'b0, busy});
    expect_now("rst_active_id", 8'h00, {5'b0, active_id});

    // Edge source 0: irq pulse two edges after src is sampled
    wr(BASE + 8'd2, 8'h01);
    wr(BASE + 8'd0, 8'h01);
    src = 8'h01;
    tick();
    src = 8'h00;
    expect_now("edge_irq_early", 8'h00, {7'b0, irq});
    tick();
    expect_now("edge_irq_fire", 8'h01, {7'b0, irq});
    expect_now("edge_active_id", 8'h00, {5'b0, active_id});
    expect_now("edge_busy_fire", 8'h01, {7'b0, busy});
    tick();
    expect_now("edge_irq_one_cycle", 8'h00, {7'b0, irq});
    rd("edge_status", BASE + 8'd1, 8'h01);
    wr(BASE + 8'd3, 8'h00);
    rd("edge_status_after_eoi", BASE + 8'd1, 8'h00);
    expect_now("edge_busy_after_eoi", 8'h00, {7'b0, busy});

    // Two simultaneous edges: lower index first, the other after EOI
    wr(BASE + 8'd0, 8'hFF);
    wr(BASE + 8'd2, 8'hFF);
    src = 8'h24;
    tick();
    src = 8'h00;
    tick();
    expect_now("prio_irq_first", 8'h01, {7'b0, irq});
    expect_now("prio_first_id", 8'h02, {5'b0, active_id});
    tick();
    wr(BASE + 8'd3, 8'h00);
    expect_now("prio_gap_irq", 8'h00, {7'b0, irq});
    tick();
    expect_now("prio_irq_second", 8'h01, {7'b0, irq});
    expect_now("prio_second_id", 8'h05, {5'b0, active_id});
    tick();
    wr(BASE + 8'd3, 8'h00);
    rd("prio_status_clear", BASE + 8'd1, 8'h00);

    // Masked source still latches; set beats W1C; enabling it fires
    wr(BASE + 8'd0, 8'h00);
    src = 8'h10;
    tick();
    src = 8'h00;
    tick();
    tick();
    expect_now("mask_no_irq", 8'h00, {7'b0, irq});
    expect_now("mask_not_busy", 8'h00, {7'b0, busy});
    rd("mask_status", BASE + 8'd1, 8'h10);
    address = BASE + 8'd1;
    din     = 8'h10;
    w_en    = 1'b1;
    src     = 8'h10;
    tick();
    w_en    = 1'b0;
    src     = 8'h00;
    rd("w1c_set_wins", BASE + 8'd1, 8'h10);
    wr(BASE + 8'd0, 8'h10);
    tick();
    expect_now("unmask_irq", 8'h01, {7'b0, irq});
    expect_now("unmask_id", 8'h04, {5'b0, active_id});
    tick();
    wr(BASE + 8'd3, 8'h00);
    rd("unmask_status_after_eoi", BASE + 8'd1, 8'h00);

    // EOI while idle must not clear the active_id status bit
    wr(BASE + 8'd0, 8'h00);
    src = 8'h10;
    tick();
    src = 8'h00;
    wr(BASE + 8'd3, 8'h00);
    rd("idle_eoi_ignored", BASE + 8'd1, 8'h10);
    wr(BASE + 8'd1, 8'h10);
    rd("w1c_clears", BASE + 8'd1, 8'h00);

    // Level source 6 held high re-fires two cycles after EOI
    wr(BASE + 8'd2, 8'h00);
    wr(BASE + 8'd0, 8'h40);
    src = 8'h40;
    wait_irq(8, got);
    expect_now("level_irq_seen", 8'h01, {7'b0, got});
    expect_now("level_id", 8'h06, {5'b0, active_id});
    tick();
    wr(BASE + 8'd3, 8'h00);
    expect_now("level_gap_irq", 8'h00, {7'b0, irq});
    tick();
    expect_now("level_refire", 8'h01, {7'b0, irq});
    tick();
    src = 8'h00;
    wr(BASE + 8'd1, 8'h40);
    wr(BASE + 8'd3, 8'h00);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (irq) hits++;
    end
    expect_now("level_quiet", 8'h00, 8'(hits));

    // Reset while in SERVICE returns everything to reset values
    src = 8'h40;
    wait_irq(8, got);
    expect_now("svc_irq_seen", 8'h01, {7'b0, got});
    tick();
    rd("svc_active_read", BASE + 8'd3, 8'h86);
    expect_now("svc_busy", 8'h01, {7'b0, busy});
    src   = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_now("rst2_busy", 8'h00, {7'b0, busy});
    expect_now("rst2_dout", 8'h00, dout);
    expect_now("rst2_irq", 8'h00, {7'b0, irq});
    expect_now("rst2_active_id", 8'h00, {5'b0, active_id});
    rd("rst2_status", BASE + 8'd1, 8'h00);
    rd("rst2_active_read", BASE + 8'd3, 8'h00);
    wr(BASE + 8'd0, 8'h5A);
    rd("enable_readback", BASE + 8'd0, 8'h5A);
    rd("unmapped_read", 8'h20, 8'h00);
    expect_now("scoreboard_drained", 8'h00, 8'(exp_q.size()));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
